// File: rtl/microcode_sequencer.sv
// -----------------------------------------------------------------------------
// microcode_sequencer
//   Walks a microcode routine held in an external uop buffer. Each buffer entry
//   is one bundle of SLOTS uop slots. Valid slots are issued one per cycle to
//   the back end over a valid/ready handshake. Continuation bits chain bundles
//   together until a slot with cont=0 is accepted or the routine is flushed.
//
//   Slot layout (slot 0 at the bundle MSB end), MSB first:
//     instr[INSTR_W] | tag[TAG_W] | cont | valid
//
// Optional build macro:
//   MC_TAG_KILL_EN  - when defined, a valid slot whose tag matches kill_tag
//                     while kill_valid=1 is squashed into a bubble. When not
//                     defined, kill_valid/kill_tag are ignored.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          begin routine at start_addr (only honoured in IDLE)
//   start_addr     first bundle address
//   flush          abort current routine (no done pulse)
//   uop_addr       buffer read address (always equals pc)
//   uop            bundle at uop_addr, combinational read
//   out_valid      slot presented to back end
//   out_ready      back end accepts
//   out_instr      presented instruction (0 when out_valid=0)
//   out_tag        presented branch tag (0 when out_valid=0)
//   busy           sequencer not IDLE
//   done           one-cycle pulse when the final (cont=0) slot is accepted
//   wrap_err       sticky flag: pc advanced past the last buffer entry
//   kill_valid     squash request (optional feature)
//   kill_tag       tag to squash (optional feature)
// -----------------------------------------------------------------------------

// Splits one slot into its fields.
module mc_slot_decode #(
  parameter int INSTR_W = 32,
  parameter int TAG_W   = 2,
  localparam int SLOT_W = INSTR_W + TAG_W + 2
) (
  input  logic [SLOT_W-1:0]  slot,
  output logic [INSTR_W-1:0] instr,
  output logic [TAG_W-1:0]   tag,
  output logic               cont,
  output logic               vld
);
  assign instr = slot[SLOT_W-1 -: INSTR_W];
  assign tag   = slot[TAG_W+1 -: TAG_W];
  assign cont  = slot[1];
  assign vld   = slot[0];
endmodule

module microcode_sequencer #(
  parameter int UOP_BUF_SIZE = 128,
  parameter int SLOTS        = 2,
  parameter int INSTR_W      = 32,
  parameter int TAG_W        = 2,
  localparam int AW            = $clog2(UOP_BUF_SIZE),
  localparam int SLOT_W        = INSTR_W + TAG_W + 2,
  localparam int UOP_BUF_WIDTH = SLOTS * SLOT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [AW-1:0]            start_addr,
  input  logic                     flush,
  output logic [AW-1:0]            uop_addr,
  input  logic [UOP_BUF_WIDTH-1:0] uop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     busy,
  output logic                     done,
  output logic                     wrap_err,
  input  logic                     kill_valid,
  input  logic [TAG_W-1:0]         kill_tag
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SLOTS - 1);
  localparam logic [AW-1:0] PC_MAX   = AW'(UOP_BUF_SIZE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic [1:0]               state;
  logic [AW-1:0]            pc;
  logic [IW-1:0]            idx;
  logic [UOP_BUF_WIDTH-1:0] bundle;
  logic                     wrap_q;

  // Per-slot field decode of the latched bundle.
  logic [SLOTS-1:0][INSTR_W-1:0] s_instr;
  logic [SLOTS-1:0][TAG_W-1:0]   s_tag;
  logic [SLOTS-1:0]              s_cont;
  logic [SLOTS-1:0]              s_vld;

  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    mc_slot_decode #(.INSTR_W(INSTR_W), .TAG_W(TAG_W)) u_dec (
      .slot  (bundle[UOP_BUF_WIDTH-1-k*SLOT_W -: SLOT_W]),
      .instr (s_instr[k]),
      .tag   (s_tag[k]),
      .cont  (s_cont[k]),
      .vld   (s_vld[k])
    );
  end

  logic [INSTR_W-1:0] cur_instr;
  logic [TAG_W-1:0]   cur_tag;
  logic               cur_cont;
  logic               cur_vld;
  logic               killed;

  assign cur_instr = s_instr[idx];
  assign cur_tag   = s_tag[idx];
  assign cur_cont  = s_cont[idx];
  assign cur_vld   = s_vld[idx];

`ifdef MC_TAG_KILL_EN
  // Squashed slots degrade to bubbles; cont of a squashed slot is ignored.
  assign killed = kill_valid && (cur_tag == kill_tag);
`else
  logic unused_kill;
  assign unused_kill = ^{kill_valid, kill_tag};
  assign killed      = 1'b0;
`endif

  logic issue, slot_live, hs, last, step;

  assign issue     = (state == S_ISSUE);
  assign slot_live = issue && cur_vld && !killed;
  // Flush outranks the handshake: a slot presented during flush is not taken.
  assign hs        = slot_live && out_ready && !flush;
  assign last      = (idx == LAST_IDX);
  // Move past the current slot: bubble, or accepted slot that continues.
  assign step      = issue && !flush && (!slot_live || (out_ready && cur_cont));

  assign out_valid = slot_live;
  assign out_instr = slot_live ? cur_instr : '0;
  assign out_tag   = slot_live ? cur_tag   : '0;
  assign done      = hs && !cur_cont;
  assign busy      = (state != S_IDLE);
  assign uop_addr  = pc;
  assign wrap_err  = wrap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      pc     <= '0;
      idx    <= '0;
      bundle <= '0;
      wrap_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc     <= start_addr;
            wrap_q <= 1'b0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            bundle <= uop;
            idx    <= '0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (flush || done) begin
            state <= S_IDLE;
          end else if (step) begin
            if (last) begin
              state <= S_FETCH;
              if (pc == PC_MAX) begin
                pc     <= '0;
                wrap_q <= 1'b1;
              end else begin
                pc <= pc + AW'(1);
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;
  localparam int SIZE = 128, SLOTS = 2, IW = 32, TW = 2, AW = 7;
  localparam int SW = IW + TW + 2, BW = SLOTS * SW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          flush = 1'b0;
  logic [AW-1:0] uop_addr;
  logic [BW-1:0] uop;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_instr;
  logic [TW-1:0] out_tag;
  logic          busy, done, wrap_err;
  logic          kill_valid = 1'b0;
  logic [TW-1:0] kill_tag = '0;

  logic [BW-1:0] mem [SIZE];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  assign uop = mem[uop_addr];

  microcode_sequencer #(.UOP_BUF_SIZE(SIZE), .SLOTS(SLOTS), .INSTR_W(IW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .flush(flush),
    .uop_addr(uop_addr), .uop(uop), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_tag(out_tag), .busy(busy), .done(done),
    .wrap_err(wrap_err), .kill_valid(kill_valid), .kill_tag(kill_tag)
  );

  function automatic logic [SW-1:0] mk(input logic [IW-1:0] i, input logic [TW-1:0] t,
                                       input logic c, input logic v);
    return {i, t, c, v};
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Pulse start for one cycle; returns positioned in cycle t+1.
  task automatic kick(input logic [AW-1:0] a);
    start = 1'b1; start_addr = a;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0d exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0d exp=0", out_valid); end
    checks++; if (uop_addr !== 7'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", uop_addr); end
    checks++; if (done !== 1'b0 || wrap_err !== 1'b0) begin failures++; $display("FAIL rst_flags got=%0d%0d exp=00", done, wrap_err); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    kick(7'd5);
    // t+1: FETCH
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || uop_addr !== 7'd5) begin failures++; $display("FAIL basic_fetch got=%0d/%0d/%0d exp=1/0/5", busy, out_valid, uop_addr); end
    cyc(); // t+2
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h1205021 || out_tag !== 2'd2) begin failures++; $display("FAIL basic_hs0 got=%0d/%h/%0d exp=1/01205021/2", out_valid, out_instr, out_tag); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_nodone got=%0d exp=0", done); end
    cyc(); // t+3
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h25270004) begin failures++; $display("FAIL basic_hs1 got=%0d/%h exp=1/25270004", out_valid, out_instr); end
    cyc(); // t+4
    checks++; if (out_valid !== 1'b0 || uop_addr !== 7'd6 || out_instr !== 32'h0) begin failures++; $display("FAIL basic_fetch2 got=%0d/%0d/%h exp=0/6/0", out_valid, uop_addr, out_instr); end
    cyc(); // t+5
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h25270005 || out_tag !== 2'd1 || done !== 1'b1) begin failures++; $display("FAIL basic_hs2 got=%0d/%h/%0d/%0d exp=1/25270005/1/1", out_valid, out_instr, out_tag, done); end
    cyc(); // t+6
    checks++; if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_idle got=%0d/%0d/%0d exp=0/0/0", busy, done, out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    kick(7'd10);
    cyc(); // t+2
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_instr !== 32'hA0A0 || out_tag !== 2'd1) begin failures++; $display("FAIL bp_stall%0d got=%0d/%h/%0d exp=1/0000a0a0/1", i, out_valid, out_instr, out_tag); end
      cyc();
    end
    out_ready = 1'b1; #1; // t+5: accepted at end of this cycle
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'hA0A0 || done !== 1'b0) begin failures++; $display("FAIL bp_accept got=%0d/%h/%0d exp=1/0000a0a0/0", out_valid, out_instr, done); end
    cyc(); // t+6: invalid slot 1 -> bubble
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || out_instr !== 32'h0 || uop_addr !== 7'd10) begin failures++; $display("FAIL bp_bubble got=%0d/%0d/%h/%0d exp=0/1/0/10", out_valid, busy, out_instr, uop_addr); end
    cyc(); // t+7: FETCH pc+1
    checks++; if (out_valid !== 1'b0 || uop_addr !== 7'd11) begin failures++; $display("FAIL bp_next got=%0d/%0d exp=0/11", out_valid, uop_addr); end
    cyc(); // t+8
    checks++; if (out_instr !== 32'hB0B0 || done !== 1'b1) begin failures++; $display("FAIL bp_last got=%h/%0d exp=0000b0b0/1", out_instr, done); end
    cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle got=%0d exp=0", busy); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    kick(7'd127);
    checks++; if (uop_addr !== 7'd127 || wrap_err !== 1'b0) begin failures++; $display("FAIL wrap_pre got=%0d/%0d exp=127/0", uop_addr, wrap_err); end
    cyc(); cyc(); // t+3: second slot of 127 accepted
    checks++; if (out_instr !== 32'h7F1 || wrap_err !== 1'b0) begin failures++; $display("FAIL wrap_s1 got=%h/%0d exp=000007f1/0", out_instr, wrap_err); end
    cyc(); // t+4: FETCH at 0
    checks++; if (uop_addr !== 7'd0 || wrap_err !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL wrap_set got=%0d/%0d/%0d exp=0/1/1", uop_addr, wrap_err, busy); end
    out_ready = 1'b0;
    cyc(); // t+5: execution continues from bundle 0
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h100) begin failures++; $display("FAIL wrap_cont got=%0d/%h exp=1/00000100", out_valid, out_instr); end
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0; out_ready = 1'b1;
    checks++; if (busy !== 1'b0 || wrap_err !== 1'b1) begin failures++; $display("FAIL wrap_hold got=%0d/%0d exp=0/1", busy, wrap_err); end
    cyc(); cyc();
    checks++; if (wrap_err !== 1'b1) begin failures++; $display("FAIL wrap_sticky got=%0d exp=1", wrap_err); end
    kick(7'd5);
    checks++; if (wrap_err !== 1'b0) begin failures++; $display("FAIL wrap_clear got=%0d exp=0", wrap_err); end
    for (int i = 0; i < 6; i++) cyc(); // let the basic routine finish
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrap_finish got=%0d exp=0", busy); end
  endtask

  task automatic test_flush();
    int seen;
    out_ready = 1'b0;
    kick(7'd6);
    cyc(); // t+2: final (cont=0) slot stalled
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h25270005) begin failures++; $display("FAIL fl_stall got=%0d/%h exp=1/25270005", out_valid, out_instr); end
    flush = 1'b1; out_ready = 1'b1; #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL fl_nodone got=%0d exp=0", done); end
    cyc();
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL fl_idle got=%0d/%0d/%0d exp=0/0/0", busy, out_valid, done); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin cyc(); if (out_valid || done) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL fl_quiet got=%0d exp=0", seen); end
  endtask

  task automatic test_start_busy();
    out_ready = 1'b0;
    kick(7'd10);
    cyc(); // stalled on slot 0 of bundle 10
    start = 1'b1; start_addr = 7'd5;
    cyc();
    start = 1'b0;
    checks++; if (uop_addr !== 7'd10 || out_instr !== 32'hA0A0) begin failures++; $display("FAIL sb_ignored got=%0d/%h exp=10/0000a0a0", uop_addr, out_instr); end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    // start and flush together in IDLE: start wins
    start = 1'b1; flush = 1'b1; start_addr = 7'd5;
    cyc();
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b1 || uop_addr !== 7'd5) begin failures++; $display("FAIL sb_startwins got=%0d/%0d exp=1/5", busy, uop_addr); end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sb_fetchflush got=%0d exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    kick(7'd127);
    cyc(); cyc(); cyc(); // t+4: wrapped, wrap_err=1
    out_ready = 1'b0;
    cyc(); // t+5: ISSUE stalled at bundle 0
    checks++; if (wrap_err !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL rm_pre got=%0d/%0d exp=1/1", wrap_err, out_valid); end
    kick(7'd0); // no effect while busy; just moves time
    reset = 1'b1;
    cyc();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || uop_addr !== 7'd0 || wrap_err !== 1'b0) begin failures++; $display("FAIL rm_state got=%0d/%0d/%0d/%0d exp=0/0/0/0", busy, out_valid, uop_addr, wrap_err); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_kill();
    out_ready = 1'b1; kill_valid = 1'b1; kill_tag = 2'd2;
    kick(7'd5);
    cyc(); // t+2
`ifdef MC_TAG_KILL_EN
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL kill_b0 got=%0d exp=0", out_valid); end
    cyc();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL kill_b1 got=%0d/%0d exp=0/1", out_valid, busy); end
`else
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h1205021) begin failures++; $display("FAIL kill_ign0 got=%0d/%h exp=1/01205021", out_valid, out_instr); end
    cyc();
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h25270004) begin failures++; $display("FAIL kill_ign1 got=%0d/%h exp=1/25270004", out_valid, out_instr); end
`endif
    cyc(); cyc(); // t+5
    checks++; if (out_instr !== 32'h25270005 || done !== 1'b1) begin failures++; $display("FAIL kill_last got=%h/%0d exp=25270005/1", out_instr, done); end
    cyc();
    kill_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL kill_idle got=%0d exp=0", busy); end
  endtask

  initial begin
    for (int i = 0; i < SIZE; i++) mem[i] = '0;
    mem[5]   = {mk(32'h1205021, 2'd2, 1'b1, 1'b1), mk(32'h25270004, 2'd2, 1'b1, 1'b1)};
    mem[6]   = {mk(32'h25270005, 2'd1, 1'b0, 1'b1), mk(32'h0, 2'd0, 1'b0, 1'b0)};
    mem[10]  = {mk(32'hA0A0, 2'd1, 1'b1, 1'b1), mk(32'hDEAD, 2'd3, 1'b1, 1'b0)};
    mem[11]  = {mk(32'hB0B0, 2'd0, 1'b0, 1'b1), mk(32'h0, 2'd0, 1'b0, 1'b0)};
    mem[127] = {mk(32'h7F0, 2'd0, 1'b1, 1'b1), mk(32'h7F1, 2'd0, 1'b1, 1'b1)};
    mem[0]   = {mk(32'h100, 2'd0, 1'b1, 1'b1), mk(32'h101, 2'd0, 1'b1, 1'b1)};
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_flush();
    test_start_busy();
    test_reset_mid();
    test_kill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
